fsm_op_scheduler: RTL

- Shares one fsm_module (insert/release mechanism controller) between two requesters (ports 0/1).
- Arbitrates round-robin and drives fsm_module's EN/DIRECTION/START/FAULT inputs.
- Confirms each operation via the EN_INSERT/EN_RELEASE echo, times it, and reports done/error per requester.
- Latches plant faults, holds the mechanism in alarm until software clears it, then runs a fixed recovery interval.

---
 rtl/fsm_op_scheduler_pkg.sv | 25 ++
 rtl/fsm_op_scheduler_rr_arbiter2.sv | 38 +++
 rtl/fsm_op_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fsm_op_scheduler_pkg.sv
// Shared definitions for the fsm_module operation scheduler.
//   state_t      : scheduler state encoding
//   DIR_*        : DIRECTION encoding towards fsm_module (1 = insert, 0 = release)
//   CNT_W        : width of the saturating phase counter
//   sat_inc()    : saturating increment for the phase counter
package fsm_op_scheduler_pkg;

    localparam int   CNT_W       = 8;
    localparam logic DIR_INSERT  = 1'b1;
    localparam logic DIR_RELEASE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RUN,
        ST_DONE,
        ST_ALARM,
        ST_RECOVER
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fsm_op_scheduler_rr_arbiter2.sv
// Two-way round-robin picker with a registered one-hot grant.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request levels of ports 0/1
//   load       : take the current pick as the new owner (grant + owner update)
//   clear      : drop the grant (owner is remembered for the next round)
//   pick       : combinational choice among the current requests
//   grant      : registered one-hot grant, 0 when nobody owns the mechanism
//   owner      : last port granted (rr_last); resets to 1 so port 0 wins first
module rr_arbiter2
    import fsm_op_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       load,
    input  logic       clear,
    output logic       pick,
    output logic [1:0] grant,
    output logic       owner
);

    // With both ports requesting, the one that did not win last goes next;
    // with a single request, req[1] alone is the index of the set bit.
    assign pick = (req == 2'b11) ? ~owner : req[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant <= 2'b00;
            owner <= 1'b1;
        end else if (load) begin
            grant <= pick ? 2'b10 : 2'b01;
            owner <= pick;
        end else if (clear) begin
            grant <= 2'b00;
        end
    end

endmodule

// File: rtl/fsm_op_scheduler.sv
// Shares one fsm_module between two requesters. Grants round-robin, drives
// EN/DIRECTION/START, waits for the matching EN_INSERT/EN_RELEASE echo, times
// the operation and reports done/err to the owner. Plant faults force ALARM
// until software clears it, followed by a fixed RECOVER interval.
//   req/req_dir           : per-port request level and direction (1=insert)
//   fault_sense, alarm_clr: plant fault level, alarm clear pulse
//   fsm_insert/release/alarm : echoes and alarm from fsm_module
//   fsm_en/dir/start/fault   : registered controls to fsm_module
//   grant, done, err      : one-hot owner, completion and error pulses
//   busy, alarm_latched   : not idle, fault latched until clear accepted
module fsm_op_scheduler
    import fsm_op_scheduler_pkg::*;
#(
    parameter int OP_CYCLES      = 8,
    parameter int ACK_TIMEOUT    = 6,
    parameter int RECOVER_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] req_dir,
    input  logic       fault_sense,
    input  logic       alarm_clr,
    input  logic       fsm_insert,
    input  logic       fsm_release,
    input  logic       fsm_alarm,
    output logic       fsm_en,
    output logic       fsm_dir,
    output logic       fsm_start,
    output logic       fsm_fault,
    output logic [1:0] grant,
    output logic [1:0] done,
    output logic [1:0] err,
    output logic       busy,
    output logic       alarm_latched
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             dir_reg, dir_next;
    logic             alarm_next;
    logic [1:0]       done_next, err_next;
    logic             arb_load, arb_clear, arb_pick, owner;
    logic [1:0]       owner_oh;
    logic             fault_any, echo, active_next;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .load  (arb_load),
        .clear (arb_clear),
        .pick  (arb_pick),
        .grant (grant),
        .owner (owner)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_owner_oh
            assign owner_oh[gi] = (owner == 1'(gi));
        end
    endgenerate

    assign fault_any = fault_sense | fsm_alarm;
    // Only the echo matching the latched direction confirms the operation.
    assign echo      = (dir_reg == DIR_INSERT) ? fsm_insert : fsm_release;

    always_comb begin
        state_next = state_reg;
        alarm_next = alarm_latched;
        done_next  = 2'b00;
        err_next   = 2'b00;
        arb_load   = 1'b0;
        arb_clear  = 1'b0;

        if (fault_any) begin
            // Faults override every other transition, including a completion
            // on the same edge, which is then reported as an error.
            state_next = ST_ALARM;
            alarm_next = 1'b1;
            arb_clear  = 1'b1;
            if (state_reg == ST_ISSUE || state_reg == ST_RUN) begin
                err_next = owner_oh;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|req) begin
                        arb_load   = 1'b1;
                        state_next = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (echo) begin
                        state_next = ST_RUN;
                    end else if (cnt_reg == CNT_W'(ACK_TIMEOUT - 1)) begin
                        err_next   = owner_oh;
                        arb_clear  = 1'b1;
                        state_next = ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (!echo) begin
                        err_next   = owner_oh;
                        arb_clear  = 1'b1;
                        state_next = ST_DONE;
                    end else if (cnt_reg == CNT_W'(OP_CYCLES - 1)) begin
                        done_next  = owner_oh;
                        arb_clear  = 1'b1;
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                ST_ALARM: begin
                    // fault_any is already low here, so the clear is safe.
                    if (alarm_clr) begin
                        alarm_next = 1'b0;
                        state_next = ST_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    if (cnt_reg == CNT_W'(RECOVER_CYCLES - 1)) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        // Every phase counts from zero on entry and saturates while it lasts.
        cnt_next    = (state_next != state_reg) ? '0 : sat_inc(cnt_reg);
        dir_next    = arb_load ? req_dir[arb_pick] : dir_reg;
        active_next = (state_next == ST_ISSUE) || (state_next == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            dir_reg       <= DIR_RELEASE;
            alarm_latched <= 1'b0;
            done          <= 2'b00;
            err           <= 2'b00;
            fsm_en        <= 1'b0;
            fsm_dir       <= 1'b0;
            fsm_start     <= 1'b0;
            fsm_fault     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            dir_reg       <= dir_next;
            alarm_latched <= alarm_next;
            done          <= done_next;
            err           <= err_next;
            fsm_en        <= active_next;
            fsm_dir       <= active_next & dir_next;
            fsm_start     <= active_next;
            fsm_fault     <= (state_next == ST_ALARM);
            busy          <= (state_next != ST_IDLE);
        end
    end

endmodule
